// File: rtl/multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier controller: FSM state
// encoding and the width rule for the iteration counter.
package multiplier_pkg;

   // Controller states; encoding is fixed so other tools and datapath
   // documentation can refer to the numeric values.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CALC = 2'd2,
      DONE = 2'd3
   } state_t;

   // Bits needed to hold an iteration count in the range 0..word_length.
   function automatic int unsigned count_width(input int unsigned word_length);
      return $clog2(word_length + 1);
   endfunction

endpackage

// File: rtl/multiplier_controller_counter.sv
// Saturating iteration counter: counts completed CALC cycles and stops at
// WORD_LENGTH, so it never wraps.
module iteration_counter
   import multiplier_pkg::*;
#(
   parameter int unsigned WORD_LENGTH = 4
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 clear,
   input  logic                                 enable,
   output logic [count_width(WORD_LENGTH)-1:0]  count
);

   localparam int unsigned   CW        = count_width(WORD_LENGTH);
   localparam logic [CW-1:0] COUNT_MAX = CW'(WORD_LENGTH);

   // Synchronous reset/clear take priority; increment only below the limit.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != COUNT_MAX)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/multiplier_controller.sv
// Control FSM for a shift-and-add multiplier datapath. Sequences operand
// load, WORD_LENGTH shift/add iterations and a one-cycle ready pulse. It
// performs no arithmetic itself.
module multiplier_controller
   import multiplier_pkg::*;
#(
   parameter int unsigned WORD_LENGTH = 4,
   parameter int unsigned WORD        = WORD_LENGTH * 2
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 start,
   input  logic                                 multiplier_lsb,
   output logic                                 load,
   output logic                                 shift,
   output logic                                 add_select,
   output logic                                 busy,
   output logic                                 ready,
   output logic [count_width(WORD_LENGTH)-1:0]  iteration
);

   localparam int unsigned   CW        = count_width(WORD_LENGTH);
   localparam logic [CW-1:0] LAST_ITER = CW'(WORD_LENGTH - 1);

   // The product width only matters to the datapath; an undersized value
   // simply has nothing to build here.
   if (WORD < 2 * WORD_LENGTH) begin : g_word_narrower_than_product
   end

   state_t state;
   logic   count_clear;
   logic   count_enable;

   // Count is zeroed everywhere outside CALC, so LOAD and IDLE always show 0
   // and DONE shows the saturated WORD_LENGTH for its single cycle.
   assign count_clear  = (state != CALC);
   assign count_enable = (state == CALC);

   iteration_counter #(
      .WORD_LENGTH (WORD_LENGTH)
   ) u_iteration_counter (
      .clk    (clk),
      .reset  (reset),
      .clear  (count_clear),
      .enable (count_enable),
      .count  (iteration)
   );

   // Mux select follows the multiplier LSB in the same cycle, only in CALC.
   assign add_select = (state == CALC) & multiplier_lsb;

   // State register with registered Moore outputs: each arm sets the
   // outputs that belong to the state being entered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         load  <= 1'b0;
         shift <= 1'b0;
         busy  <= 1'b0;
         ready <= 1'b0;
      end else begin
         load  <= 1'b0;
         shift <= 1'b0;
         busy  <= 1'b0;
         ready <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= LOAD;
                  load  <= 1'b1;
                  busy  <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            LOAD: begin
               state <= CALC;
               shift <= 1'b1;
               busy  <= 1'b1;
            end
            CALC: begin
               if (iteration == LAST_ITER) begin
                  state <= DONE;
                  ready <= 1'b1;
               end else begin
                  state <= CALC;
                  shift <= 1'b1;
                  busy  <= 1'b1;
               end
            end
            DONE: begin
               if (start) begin
                  state <= LOAD;
                  load  <= 1'b1;
                  busy  <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
